rename_regfile_mp: RTL and testbench

//  Architectural register file with per-register rename tags for the out-of-order core, generalised to

---
 rtl/rename_regfile_mp_pkg.sv | 24 ++
 rtl/rename_regfile_mp_rrf_read_port.sv | 37 +++
 rtl/rename_regfile_mp.sv | 123 ++++++++++++
 tb/tb_rename_regfile_mp.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rename_regfile_mp_pkg.sv
`default_nettype none
// ============================================================================
// rename_regfile_mp_pkg : shared widths and helpers for the rename register file
// Revision 1.0
// ============================================================================
package rename_regfile_mp_pkg;

   localparam int XLEN = 32;
   localparam int ROB_W = 4;
   localparam int TAG_W = ROB_W + 1;
   localparam int TAG_READY = 0;
   localparam logic [4:0] REG_ZERO = 5'd0;

   function automatic logic [5:0] popcount32(input logic [31:0] v);
      logic [5:0] n;
      n = '0;
      for (int i = 0; i < 32; i++) begin
         n = n + {5'd0, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rename_regfile_mp_rrf_read_port.sv
`default_nettype none
// ============================================================================
// rrf_read_port : one combinational query port with commit-bypass priority mux
// Revision 1.0
// ============================================================================
module rrf_read_port #(
   parameter int XLEN    = 32,
   parameter int ROB_W   = 4,
   parameter int NCOMMIT = 2
) (
   input  logic [4:0]              rs_i,
   input  logic [XLEN-1:0]         st_val_i,
   input  logic [ROB_W:0]          st_tag_i,
   input  logic [NCOMMIT-1:0]      commit_en_i,
   input  logic [NCOMMIT*5-1:0]    commit_rd_i,
   input  logic [NCOMMIT*XLEN-1:0] commit_val_i,
   input  logic [NCOMMIT-1:0]      commit_true_i,
   output logic [XLEN-1:0]         rs_val_o,
   output logic [ROB_W:0]          rs_tag_o
);
   import rename_regfile_mp_pkg::*;

   // Ascending scan: the highest-numbered matching true commit ends up selected.
   always_comb begin
      rs_val_o = st_val_i;
      rs_tag_o = st_tag_i;
      for (int c = 0; c < NCOMMIT; c++) begin
         if (commit_en_i[c] && commit_true_i[c] && (rs_i != REG_ZERO) &&
             (commit_rd_i[c*5 +: 5] == rs_i)) begin
            rs_val_o = commit_val_i[c*XLEN +: XLEN];
            rs_tag_o = '0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/rename_regfile_mp.sv
`default_nettype none
// ============================================================================
// rename_regfile_mp : architectural register file with per-register ROB rename tags
// Revision 1.0
// ============================================================================
module rename_regfile_mp #(
   parameter int XLEN    = rename_regfile_mp_pkg::XLEN,
   parameter int ROB_W   = rename_regfile_mp_pkg::ROB_W,
   parameter int NISSUE  = 2,
   parameter int NCOMMIT = 2,
   parameter int NREAD   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rdy,
   input  logic                     rollback,
   input  logic [NCOMMIT-1:0]       commit_en,
   input  logic [NCOMMIT*5-1:0]     commit_rd,
   input  logic [NCOMMIT*XLEN-1:0]  commit_val,
   input  logic [NCOMMIT*ROB_W-1:0] commit_rob,
   input  logic [NISSUE-1:0]        issue_en,
   input  logic [NISSUE*5-1:0]      issue_rd,
   input  logic [NISSUE*ROB_W-1:0]  issue_rob,
   input  logic [NREAD*5-1:0]       rs,
   output logic [NREAD*XLEN-1:0]    rs_val,
   output logic [NREAD*(ROB_W+1)-1:0] rs_tag,
   output logic [5:0]               busy_cnt
);
   import rename_regfile_mp_pkg::*;

   localparam int TW = ROB_W + 1;

   logic [XLEN-1:0]    val_q [32];
   logic [XLEN-1:0]    val_d [32];
   logic [TW-1:0]      tag_q [32];
   logic [TW-1:0]      tag_d [32];
   logic [5:0]         busy_cnt_q;
   logic [5:0]         busy_cnt_d;
   logic [31:0]        busy_vec;
   logic [NCOMMIT-1:0] commit_true;

   // A commit only retires the rename if the register still points at that ROB entry.
   always_comb begin
      commit_true = '0;
      for (int c = 0; c < NCOMMIT; c++) begin
         commit_true[c] = commit_en[c] && (commit_rd[c*5 +: 5] != REG_ZERO) &&
                          (tag_q[commit_rd[c*5 +: 5]] == {1'b1, commit_rob[c*ROB_W +: ROB_W]});
      end
   end

   always_comb begin
      for (int r = 0; r < 32; r++) begin
         val_d[r] = val_q[r];
         tag_d[r] = tag_q[r];
      end
      for (int c = 0; c < NCOMMIT; c++) begin
         if (commit_en[c] && (commit_rd[c*5 +: 5] != REG_ZERO)) begin
            val_d[commit_rd[c*5 +: 5]] = commit_val[c*XLEN +: XLEN];
            if (commit_true[c]) begin
               tag_d[commit_rd[c*5 +: 5]] = '0;
            end
         end
      end
      if (rollback) begin
         for (int r = 0; r < 32; r++) begin
            tag_d[r] = '0;
         end
      end else begin
         for (int k = 0; k < NISSUE; k++) begin
            if (issue_en[k] && (issue_rd[k*5 +: 5] != REG_ZERO)) begin
               tag_d[issue_rd[k*5 +: 5]] = {1'b1, issue_rob[k*ROB_W +: ROB_W]};
            end
         end
      end
      for (int r = 0; r < 32; r++) begin
         busy_vec[r] = tag_d[r][TW-1];
      end
      busy_cnt_d = popcount32(busy_vec);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            val_q[r] <= '0;
            tag_q[r] <= '0;
         end
         busy_cnt_q <= '0;
      end else if (rdy) begin
         for (int r = 0; r < 32; r++) begin
            val_q[r] <= val_d[r];
            tag_q[r] <= tag_d[r];
         end
         busy_cnt_q <= busy_cnt_d;
      end
   end

   assign busy_cnt = busy_cnt_q;

   generate
      for (genvar p = 0; p < NREAD; p++) begin : g_read
         logic [4:0] rs_sel;
         assign rs_sel = rs[p*5 +: 5];

         rrf_read_port #(
            .XLEN    (XLEN),
            .ROB_W   (ROB_W),
            .NCOMMIT (NCOMMIT)
         ) u_port (
            .rs_i          (rs_sel),
            .st_val_i      (val_q[rs_sel]),
            .st_tag_i      (tag_q[rs_sel]),
            .commit_en_i   (commit_en),
            .commit_rd_i   (commit_rd),
            .commit_val_i  (commit_val),
            .commit_true_i (commit_true),
            .rs_val_o      (rs_val[p*XLEN +: XLEN]),
            .rs_tag_o      (rs_tag[p*TW +: TW])
         );
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rename_regfile_mp.sv
`default_nettype none
// ============================================================================
// tb_rename_regfile_mp : directed scoreboard bench for rename_regfile_mp
// Revision 1.0
// ============================================================================
module tb_rename_regfile_mp;

   localparam int XLEN = 32;
   localparam int ROB_W = 4;
   localparam int TW = ROB_W + 1;
   localparam int NISSUE = 2;
   localparam int NCOMMIT = 2;
   localparam int NREAD = 4;

   logic clk = 1'b0;
   logic rst, rdy, rollback;
   logic [NCOMMIT-1:0]       commit_en;
   logic [NCOMMIT*5-1:0]     commit_rd;
   logic [NCOMMIT*XLEN-1:0]  commit_val;
   logic [NCOMMIT*ROB_W-1:0] commit_rob;
   logic [NISSUE-1:0]        issue_en;
   logic [NISSUE*5-1:0]      issue_rd;
   logic [NISSUE*ROB_W-1:0]  issue_rob;
   logic [NREAD*5-1:0]       rs;
   logic [NREAD*XLEN-1:0]    rs_val;
   logic [NREAD*TW-1:0]      rs_tag;
   logic [5:0]               busy_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            port;
      logic [XLEN-1:0] val;
      logic [TW-1:0]   tag;
   } sb_t;

   sb_t   sb_q[$];
   string sb_name[$];

   rename_regfile_mp #(
      .XLEN(XLEN), .ROB_W(ROB_W), .NISSUE(NISSUE), .NCOMMIT(NCOMMIT), .NREAD(NREAD)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val), .commit_rob(commit_rob),
      .issue_en(issue_en), .issue_rd(issue_rd), .issue_rob(issue_rob),
      .rs(rs), .rs_val(rs_val), .rs_tag(rs_tag), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      rollback = 1'b0;
      commit_en = '0; commit_rd = '0; commit_val = '0; commit_rob = '0;
      issue_en = '0; issue_rd = '0; issue_rob = '0;
   endtask

   task automatic set_issue(input int k, input logic [4:0] rd, input logic [ROB_W-1:0] rob);
      issue_en[k] = 1'b1;
      issue_rd[k*5 +: 5] = rd;
      issue_rob[k*ROB_W +: ROB_W] = rob;
   endtask

   task automatic set_commit(input int c, input logic [4:0] rd, input logic [XLEN-1:0] v,
                             input logic [ROB_W-1:0] rob);
      commit_en[c] = 1'b1;
      commit_rd[c*5 +: 5] = rd;
      commit_val[c*XLEN +: XLEN] = v;
      commit_rob[c*ROB_W +: ROB_W] = rob;
   endtask

   // Point a query port at a register and record what it must return.
   task automatic expect_q(input string name, input int p, input logic [4:0] r,
                           input logic [XLEN-1:0] v, input logic [TW-1:0] t);
      sb_t e;
      rs[p*5 +: 5] = r;
      e.port = p; e.val = v; e.tag = t;
      sb_q.push_back(e);
      sb_name.push_back(name);
   endtask

   task automatic drain();
      sb_t e;
      string n;
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         n = sb_name.pop_front();
         checks++;
         assert (rs_val[e.port*XLEN +: XLEN] === e.val) else begin
            errors++;
            $error("FAIL %s val: observed %h expected %h", n, rs_val[e.port*XLEN +: XLEN], e.val);
         end
         checks++;
         assert (rs_tag[e.port*TW +: TW] === e.tag) else begin
            errors++;
            $error("FAIL %s tag: observed %h expected %h", n, rs_tag[e.port*TW +: TW], e.tag);
         end
      end
   endtask

   task automatic check_busy(input string name, input logic [5:0] exp);
      checks++;
      assert (busy_cnt === exp) else begin
         errors++;
         $error("FAIL %s busy_cnt: observed %0d expected %0d", name, busy_cnt, exp);
      end
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; rs = '0;
      clear_ctl();
      tick(); tick();
      rst = 1'b0;

      // Reset state
      expect_q("rst_x5", 0, 5'd5, 32'h0, 5'h00);
      expect_q("rst_x0", 1, 5'd0, 32'h0, 5'h00);
      drain();
      check_busy("rst", 6'd0);

      // Rename then true commit with same-cycle bypass
      set_issue(0, 5'd5, 4'd3);
      tick(); clear_ctl();
      expect_q("iss_x5", 0, 5'd5, 32'h0, 5'h13);
      drain();
      check_busy("iss_x5", 6'd1);
      set_commit(0, 5'd5, 32'hDEAD, 4'd3);
      expect_q("byp_x5", 2, 5'd5, 32'hDEAD, 5'h00);
      drain();
      tick(); clear_ctl();
      expect_q("cmt_x5", 2, 5'd5, 32'hDEAD, 5'h00);
      drain();
      check_busy("cmt_x5", 6'd0);

      // Stale commit after re-rename: value updates, tag stays
      set_issue(0, 5'd7, 4'd2); tick(); clear_ctl();
      set_issue(1, 5'd7, 4'd6); tick(); clear_ctl();
      set_commit(1, 5'd7, 32'h11, 4'd2);
      expect_q("stale_nobyp", 3, 5'd7, 32'h0, 5'h16);
      drain();
      tick(); clear_ctl();
      expect_q("stale_x7", 3, 5'd7, 32'h11, 5'h16);
      drain();
      check_busy("stale", 6'd1);

      // Issue beats same-cycle true commit; highest issue slot wins
      set_issue(0, 5'd9, 4'd4); tick(); clear_ctl();
      set_commit(0, 5'd9, 32'h99, 4'd4);
      set_issue(1, 5'd9, 4'd8);
      tick(); clear_ctl();
      expect_q("iss_over_cmt", 0, 5'd9, 32'h99, 5'h18);
      drain();
      set_issue(0, 5'd3, 4'd1);
      set_issue(1, 5'd3, 4'd9);
      tick(); clear_ctl();
      expect_q("dup_issue", 1, 5'd3, 32'h0, 5'h19);
      drain();
      check_busy("dup_issue", 6'd3);

      // Duplicate commit rd: bypass from true slot, stored value from highest slot
      set_commit(0, 5'd7, 32'hA, 4'd6);
      set_commit(1, 5'd7, 32'hB, 4'd2);
      expect_q("dup_cmt_byp", 2, 5'd7, 32'hA, 5'h00);
      drain();
      tick(); clear_ctl();
      expect_q("dup_cmt_val", 2, 5'd7, 32'hB, 5'h00);
      drain();
      check_busy("dup_cmt", 6'd2);

      // Rename x1..x10 then rollback with a commit and an issue
      for (int i = 1; i <= 10; i += 2) begin
         set_issue(0, 5'(i), 4'(i));
         set_issue(1, 5'(i + 1), 4'(i + 1));
         tick(); clear_ctl();
      end
      check_busy("ren_1_10", 6'd10);
      expect_q("ren_x10", 3, 5'd10, 32'h0, 5'h1A);
      drain();
      rollback = 1'b1;
      set_commit(0, 5'd2, 32'h55, 4'd0);
      set_issue(0, 5'd4, 4'd5);
      tick(); clear_ctl();
      expect_q("rb_x2", 0, 5'd2, 32'h55, 5'h00);
      expect_q("rb_x4", 1, 5'd4, 32'h0, 5'h00);
      expect_q("rb_x9", 2, 5'd9, 32'h99, 5'h00);
      drain();
      check_busy("rb", 6'd0);

      // rdy low freezes state
      rdy = 1'b0;
      set_commit(0, 5'd12, 32'h77, 4'd0);
      set_issue(0, 5'd13, 4'd3);
      tick(); clear_ctl();
      rdy = 1'b1;
      expect_q("frz_x12", 0, 5'd12, 32'h0, 5'h00);
      expect_q("frz_x13", 1, 5'd13, 32'h0, 5'h00);
      drain();
      check_busy("frz", 6'd0);

      // x0 is never written or tagged
      set_commit(0, 5'd0, 32'hFFFF, 4'd0);
      set_issue(1, 5'd0, 4'd7);
      tick(); clear_ctl();
      expect_q("x0", 3, 5'd0, 32'h0, 5'h00);
      drain();
      check_busy("x0", 6'd0);

      // rst wins over rdy=0 and pending issue
      set_issue(0, 5'd6, 4'd1); tick(); clear_ctl();
      check_busy("pre_rst", 6'd1);
      rst = 1'b1; rdy = 1'b0;
      set_issue(0, 5'd8, 4'd2);
      tick(); clear_ctl();
      rst = 1'b0; rdy = 1'b1;
      expect_q("rst2_x6", 0, 5'd6, 32'h0, 5'h00);
      expect_q("rst2_x2", 1, 5'd2, 32'h0, 5'h00);
      drain();
      check_busy("rst2", 6'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
